// File: rtl/bus_arbiter.sv
// Two-requester bus arbiter: one owner drives the shared bus at a time, with a
// burst limit that forces handover when the other requester is waiting.
module bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,

    output logic        bus_enable,
    output logic        bus_write_enable,
    output logic [31:0] bus_address,
    output logic [31:0] bus_din,
    input  logic [31:0] bus_dout
);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_t;

    localparam logic [3:0] LastCnt = 4'(MAX_BURST - 1);

    state_t     r_state;
    logic       r_last;
    logic [3:0] r_cnt;

    state_t     w_state_next;
    logic       w_last_next;
    logic [3:0] w_cnt_next;
    logic       w_own_id;
    logic       w_own_req;
    logic       w_other_req;
    logic       w_xfer0;
    logic       w_xfer1;

    // Async reset: outputs are decoded from state, so they drop with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_last  <= 1'b1;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        w_cnt_next   = r_cnt;
        w_own_id     = (r_state == StOwn1);
        w_own_req    = w_own_id ? m1_req : m0_req;
        w_other_req  = w_own_id ? m0_req : m1_req;

        unique case (r_state)
            StIdle: begin
                // Tie goes to whichever requester did not own the bus last.
                if (m0_req && m1_req) begin
                    w_state_next = r_last ? StOwn0 : StOwn1;
                end else if (m0_req) begin
                    w_state_next = StOwn0;
                end else if (m1_req) begin
                    w_state_next = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                if (!w_own_req) begin
                    w_state_next = w_other_req ? (w_own_id ? StOwn0 : StOwn1) : StIdle;
                    w_last_next  = w_own_id;
                    w_cnt_next   = 4'd0;
                end else if (w_other_req && (r_cnt == LastCnt)) begin
                    w_state_next = w_own_id ? StOwn0 : StOwn1;
                    w_last_next  = w_own_id;
                    w_cnt_next   = 4'd0;
                end else if (r_cnt != LastCnt) begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_xfer0 = (r_state == StOwn0) && m0_req;
    assign w_xfer1 = (r_state == StOwn1) && m1_req;

    assign m0_gnt = (r_state == StOwn0);
    assign m1_gnt = (r_state == StOwn1);
    assign m0_ack = w_xfer0;
    assign m1_ack = w_xfer1;

    always_comb begin
        bus_enable       = 1'b0;
        bus_write_enable = 1'b0;
        bus_address      = 32'd0;
        bus_din          = 32'd0;
        if (w_xfer0) begin
            bus_enable       = 1'b1;
            bus_write_enable = m0_wen;
            bus_address      = m0_addr;
            bus_din          = m0_wdata;
        end else if (w_xfer1) begin
            bus_enable       = 1'b1;
            bus_write_enable = m1_wen;
            bus_address      = m1_addr;
            bus_din          = m1_wdata;
        end
    end

    assign m0_rdata = (w_xfer0 && !m0_wen) ? bus_dout : 32'd0;
    assign m1_rdata = (w_xfer1 && !m1_wen) ? bus_dout : 32'd0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic checked against an ownership/tenure model and a reference memory.
module tb_bus_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req;
    logic [1:0]  wen;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];

    logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_enable, bus_write_enable;
    logic [31:0] bus_address, bus_din, bus_dout;

    logic [31:0] mem [64];
    logic        dout_force_en;
    logic [31:0] dout_force;
    int          bus_writes = 0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_owner;
    int          m_last;
    int          m_served;
    logic [31:0] ref_mem [64];

    bus_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_req           (req[0]),
        .m0_wen           (wen[0]),
        .m0_addr          (addr[0]),
        .m0_wdata         (wdata[0]),
        .m0_gnt           (m0_gnt),
        .m0_ack           (m0_ack),
        .m0_rdata         (m0_rdata),
        .m1_req           (req[1]),
        .m1_wen           (wen[1]),
        .m1_addr          (addr[1]),
        .m1_wdata         (wdata[1]),
        .m1_gnt           (m1_gnt),
        .m1_ack           (m1_ack),
        .m1_rdata         (m1_rdata),
        .bus_enable       (bus_enable),
        .bus_write_enable (bus_write_enable),
        .bus_address      (bus_address),
        .bus_din          (bus_din),
        .bus_dout         (bus_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    assign bus_dout = dout_force_en ? dout_force : mem[bus_address[7:2]];

    // Bus-side memory: reloaded while reset is high, written only by bus cycles.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (bus_enable && bus_write_enable) begin
            mem[bus_address[7:2]] <= bus_din;
            bus_writes <= bus_writes + 1;
        end
    end

    task automatic idle_all();
        req = 2'b00;
        wen = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr[i]  = 32'd0;
            wdata[i] = 32'd0;
        end
        dout_force_en = 1'b0;
        dout_force    = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        req = 2'b11;
        reset = 1'b1;
        #1;
        vectors++;
        if ({m0_gnt, m1_gnt, m0_ack, m1_ack, bus_enable, bus_write_enable} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {m0_gnt, m1_gnt, m0_ack, m1_ack, bus_enable, bus_write_enable});
        end
        vectors++;
        if ((bus_address | bus_din | m0_rdata | m1_rdata) !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: addr %h din %h rd0 %h rd1 %h expected all 0",
                     bus_address, bus_din, m0_rdata, m1_rdata);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({m0_gnt, m1_gnt} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_no_early_grant: got %b expected 00", {m0_gnt, m1_gnt});
        end
        tick();
        vectors++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_first_tie: got %b expected 10", {m0_gnt, m1_gnt});
        end
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_single_read();
        do_reset();
        dout_force_en = 1'b1;
        dout_force    = 32'hDEAD_BEEF;
        req[0]  = 1'b1;
        wen[0]  = 1'b0;
        addr[0] = 32'h10;
        tick();
        @(negedge clk);
        vectors++;
        if ({m0_gnt, m0_ack} !== 2'b11 || m0_rdata !== 32'hDEAD_BEEF
            || bus_address !== 32'h10) begin
            miscompares++;
            $display("FAIL single_read: gnt %b ack %b rdata %h addr %h expected 1 1 deadbeef 10",
                     m0_gnt, m0_ack, m0_rdata, bus_address);
        end
        idle_all();
        tick();
    endtask

    task automatic test_burst_handover();
        int   acks0;
        int   m1_first;
        logic both;
        logic m1_acked;
        do_reset();
        acks0 = 0;
        m1_first = -1;
        both = 1'b0;
        req = 2'b11;
        addr[0] = 32'h4;
        addr[1] = 32'h8;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (m0_gnt && m1_gnt) both = 1'b1;
            if (m1_gnt && m1_first < 0) m1_first = k;
            if (m0_ack && m1_first < 0) acks0++;
            m1_acked = m1_ack;
            tick();
            if (m1_acked) req[1] = 1'b0;
        end
        vectors++;
        if (acks0 != MAXB) begin
            miscompares++;
            $display("FAIL burst_acks: got %0d expected %0d", acks0, MAXB);
        end
        vectors++;
        if (m1_first != MAXB + 1) begin
            miscompares++;
            $display("FAIL burst_handover_cycle: got %0d expected %0d", m1_first, MAXB + 1);
        end
        vectors++;
        if (both !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_dual_grant: got %b expected 0", both);
        end
        idle_all();
        tick();
    endtask

    task automatic test_drop_handover();
        do_reset();
        req[1] = 1'b1;
        addr[1] = 32'h20;
        tick();
        @(negedge clk);
        vectors++;
        if ({m1_gnt, m1_ack} !== 2'b11) begin
            miscompares++;
            $display("FAIL drop_m1_ack: got %b expected 11", {m1_gnt, m1_ack});
        end
        tick();
        req[1] = 1'b0;
        req[0] = 1'b1;
        addr[0] = 32'h24;
        @(negedge clk);
        vectors++;
        if ({m0_gnt, m1_gnt, m0_ack, m1_ack, bus_enable} !== 5'b01000) begin
            miscompares++;
            $display("FAIL drop_idle_cycle: got %b expected 01000",
                     {m0_gnt, m1_gnt, m0_ack, m1_ack, bus_enable});
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({m0_gnt, m1_gnt, m0_ack} !== 3'b101) begin
            miscompares++;
            $display("FAIL drop_m0_takes: got %b expected 101", {m0_gnt, m1_gnt, m0_ack});
        end
        idle_all();
        tick();
    endtask

    task automatic test_write_read();
        int w0;
        do_reset();
        w0 = bus_writes;
        req[1]   = 1'b1;
        wen[1]   = 1'b1;
        addr[1]  = 32'h40;
        wdata[1] = 32'h1234_5678;
        tick();
        @(negedge clk);
        vectors++;
        if ({m1_ack, bus_write_enable} !== 2'b11 || bus_address !== 32'h40
            || bus_din !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL wr_bus: ack %b we %b addr %h din %h expected 1 1 40 12345678",
                     m1_ack, bus_write_enable, bus_address, bus_din);
        end
        tick();
        req[1]  = 1'b0;
        wen[1]  = 1'b0;
        req[0]  = 1'b1;
        wen[0]  = 1'b0;
        addr[0] = 32'h40;
        tick();
        @(negedge clk);
        vectors++;
        if (m0_ack !== 1'b1 || m0_rdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL wr_readback: ack %b rdata %h expected 1 12345678", m0_ack, m0_rdata);
        end
        idle_all();
        tick();
        tick();
        vectors++;
        if (bus_writes - w0 != 1) begin
            miscompares++;
            $display("FAIL wr_count: got %0d expected 1", bus_writes - w0);
        end
    endtask

    task automatic test_async_reset();
        int w0;
        do_reset();
        req[1]   = 1'b1;
        wen[1]   = 1'b1;
        addr[1]  = 32'h80;
        wdata[1] = 32'hA5A5_0F0F;
        tick();
        #2;
        vectors++;
        if ({m1_gnt, bus_enable, bus_write_enable} !== 3'b111) begin
            miscompares++;
            $display("FAIL areset_pre: got %b expected 111", {m1_gnt, bus_enable, bus_write_enable});
        end
        w0 = bus_writes;
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus_enable, bus_write_enable, m1_ack, m1_gnt, m0_gnt} !== 5'd0) begin
            miscompares++;
            $display("FAIL areset_drop: got %b expected 00000",
                     {bus_enable, bus_write_enable, m1_ack, m1_gnt, m0_gnt});
        end
        tick();
        vectors++;
        if (bus_writes != w0 || mem[32] === 32'hA5A5_0F0F) begin
            miscompares++;
            $display("FAIL areset_no_write: writes %0d expected %0d, mem %h", bus_writes, w0,
                     mem[32]);
        end
        idle_all();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_requester();
        int acks;
        int breaks;
        do_reset();
        acks = 0;
        breaks = 0;
        req[0] = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k > 0) begin
                if (m0_ack) acks++;
                if (!m0_gnt || m1_gnt) breaks++;
            end
            tick();
            wen[0]   = 1'($urandom_range(0, 1));
            addr[0]  = 32'($urandom_range(0, 15)) << 2;
            wdata[0] = $urandom;
        end
        vectors++;
        if (acks != 20) begin
            miscompares++;
            $display("FAIL solo_acks: got %0d expected 20", acks);
        end
        vectors++;
        if (breaks != 0) begin
            miscompares++;
            $display("FAIL solo_grant_breaks: got %0d expected 0", breaks);
        end
        idle_all();
        tick();
    endtask

    task automatic test_random();
        int          wait_cnt [2];
        int          p [2];
        logic [1:0]  e_ack;
        logic [5:0]  e_ctrl;
        logic [31:0] e_addr, e_din;
        logic [31:0] e_rd [2];
        int          act;
        do_reset();
        m_owner  = -1;
        m_last   = 1;
        m_served = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        wait_cnt[0] = 0;
        wait_cnt[1] = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            for (int x = 0; x < 2; x++) e_ack[x] = (m_owner == x) && req[x];
            act = e_ack[0] ? 0 : (e_ack[1] ? 1 : -1);
            e_ctrl = {m_owner == 0, m_owner == 1, e_ack[0], e_ack[1], act >= 0,
                      act >= 0 ? wen[act] : 1'b0};
            e_addr = act >= 0 ? addr[act] : 32'd0;
            e_din  = act >= 0 ? wdata[act] : 32'd0;
            for (int x = 0; x < 2; x++)
                e_rd[x] = (e_ack[x] && !wen[x]) ? ref_mem[addr[x][7:2]] : 32'd0;

            vectors++;
            if ({m0_gnt, m1_gnt, m0_ack, m1_ack, bus_enable, bus_write_enable} !== e_ctrl) begin
                miscompares++;
                $display("FAIL rand_ctrl cyc %0d: got %b expected %b", i,
                         {m0_gnt, m1_gnt, m0_ack, m1_ack, bus_enable, bus_write_enable}, e_ctrl);
            end
            vectors++;
            if (bus_address !== e_addr || bus_din !== e_din) begin
                miscompares++;
                $display("FAIL rand_bus cyc %0d: addr %h din %h expected %h %h", i,
                         bus_address, bus_din, e_addr, e_din);
            end
            vectors++;
            if (m0_rdata !== e_rd[0] || m1_rdata !== e_rd[1]) begin
                miscompares++;
                $display("FAIL rand_rdata cyc %0d: got %h %h expected %h %h", i,
                         m0_rdata, m1_rdata, e_rd[0], e_rd[1]);
            end
            for (int x = 0; x < 2; x++) begin
                if (e_ack[x]) begin
                    vectors++;
                    if (wait_cnt[x] > MAXB + 1) begin
                        miscompares++;
                        $display("FAIL rand_wait m%0d cyc %0d: waited %0d limit %0d", x, i,
                                 wait_cnt[x], MAXB + 1);
                    end
                    wait_cnt[x] = 0;
                end else if (req[x]) begin
                    wait_cnt[x]++;
                end
            end

            if (act >= 0 && wen[act]) ref_mem[addr[act][7:2]] = wdata[act];
            // Tenure model: served counts acks in the current ownership, capped at MAXB.
            if (m_owner < 0) begin
                if (req[0] && req[1]) m_owner = (m_last == 0) ? 1 : 0;
                else if (req[0]) m_owner = 0;
                else if (req[1]) m_owner = 1;
            end else if (!req[m_owner]) begin
                m_last   = m_owner;
                m_served = 0;
                m_owner  = req[1 - m_owner] ? 1 - m_owner : -1;
            end else begin
                m_served = (m_served + 1 > MAXB) ? MAXB : m_served + 1;
                if (req[1 - m_owner] && m_served == MAXB) begin
                    m_last   = m_owner;
                    m_served = 0;
                    m_owner  = 1 - m_owner;
                end
            end

            tick();
            p[0] = (i < 300) ? 85 : 50;
            p[1] = (i < 300) ? 85 : ((i < 450) ? 20 : 90);
            for (int x = 0; x < 2; x++) begin
                if (!req[x] || e_ack[x]) begin
                    req[x]   = ($urandom_range(0, 99) < p[x]);
                    wen[x]   = 1'($urandom_range(0, 1));
                    addr[x]  = 32'($urandom_range(0, 15)) << 2;
                    wdata[x] = $urandom;
                end
            end
        end
        idle_all();
        tick();
    endtask

    initial begin
        idle_all();
        #1;
        test_reset();
        test_single_read();
        test_burst_handover();
        test_drop_handover();
        test_write_read();
        test_async_reset();
        test_single_requester();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
